// File: rtl/avmm_mem_responder_if.sv
// Avalon-MM bus bundle between a master and the word-memory responder.
interface avmm_mem_responder_if;
    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        output slave_waitrequest,
        output slave_readdata,
        output slave_readdatavalid
    );

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        input  slave_waitrequest,
        input  slave_readdata,
        input  slave_readdatavalid
    );
endinterface

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave word memory with programmable waitrequest stalls and a
// fixed-latency read pipeline. Out-of-range and read+write commands set a
// sticky error flag; memory contents survive reset.
module avmm_mem_responder #(
    parameter int DEPTH        = 1024,
    parameter int WAIT_CYCLES  = 0,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    avmm_mem_responder_if.slave  avs,
    output logic                 err_sticky,
    output logic [15:0]          reads_served
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
    localparam logic [3:0] LP_MAXP = 4'(MAX_PENDING);

    logic [3:0]              r_stall_cnt;
    logic [3:0]              r_pending;
    logic [READ_LATENCY-1:0] r_vld;
    logic [31:0]             r_data [READ_LATENCY];
    logic                    r_err;
    logic [15:0]             r_served;
    logic [31:0]             r_mem [DEPTH];

    logic          w_cmd;
    logic          w_wait;
    logic          w_acc;
    logic          w_both;
    logic          w_oor;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_retire;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic          w_unused_addr_lsb;

    assign w_cmd    = avs.slave_read | avs.slave_write;
    // Moore stall: only registered state feeds waitrequest.
    assign w_wait   = !((r_stall_cnt == LP_WAIT) && (r_pending < LP_MAXP));
    assign w_acc    = w_cmd & !w_wait;
    assign w_both   = avs.slave_read & avs.slave_write;
    assign w_idx    = avs.slave_address[AW+1:2];
    assign w_oor    = |avs.slave_address[31:AW+2];
    // A read+write pair keeps the write and drops the read.
    assign w_wr_acc = w_acc & avs.slave_write & !w_oor;
    assign w_rd_acc = w_acc & avs.slave_read & !avs.slave_write;
    assign w_rd_word = w_oor ? 32'hDEAD_BEEF : r_mem[w_idx];
    // Byte offset within a word carries no meaning here.
    assign w_unused_addr_lsb = ^avs.slave_address[1:0];

    // A slot frees on the edge that raises readdatavalid, so a full
    // pipeline with MAX_PENDING == READ_LATENCY still sustains one read/cycle.
    generate
        if (READ_LATENCY == 1) begin : g_ret_l1
            assign w_retire = w_rd_acc;
        end else begin : g_ret_ln
            assign w_retire = r_vld[READ_LATENCY-2];
        end
    endgenerate

    // Stall counter: counts refused command cycles, restarts on accept or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 4'd0;
        end else if (!w_cmd || w_acc) begin
            r_stall_cnt <= 4'd0;
        end else if (r_stall_cnt != LP_WAIT) begin
            r_stall_cnt <= r_stall_cnt + 4'd1;
        end
    end

    // Reads in flight: up on read accept, down when its valid is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 4'd0;
        end else begin
            r_pending <= r_pending + {3'b000, w_rd_acc} - {3'b000, w_retire};
        end
    end

    // Read pipeline; data stages only load behind a valid so the output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_data[0] <= w_rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    // Sticky error and served-read counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err    <= 1'b0;
            r_served <= 16'd0;
        end else begin
            if (w_acc && (w_both || w_oor)) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_served <= r_served + 16'd1;
            end
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= avs.slave_writedata;
        end
    end

    assign avs.slave_waitrequest   = w_wait;
    assign avs.slave_readdatavalid = r_vld[READ_LATENCY-1];
    assign avs.slave_readdata      = r_data[READ_LATENCY-1];
    assign err_sticky              = r_err;
    assign reads_served            = r_served;

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: three parameterisations, a vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_avmm_mem_responder;

    localparam int P_W  [3] = '{0, 3, 0};
    localparam int P_RL [3] = '{2, 2, 4};
    localparam int P_MP [3] = '{2, 2, 2};

    typedef struct {
        logic        wr;
        logic        v;
        logic [31:0] rd;
        logic        err;
        logic [15:0] srv;
    } out_t;

    typedef struct {
        int          rise;
        logic [31:0] data;
        bit          known;
    } resp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        err_a, err_b, err_c;
    logic [15:0] srv_a, srv_b, srv_c;
    int          n_cmp = 0;
    int          n_bad = 0;

    avmm_mem_responder_if if_a ();
    avmm_mem_responder_if if_b ();
    avmm_mem_responder_if if_c ();

    avmm_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(P_W[0]), .READ_LATENCY(P_RL[0]), .MAX_PENDING(P_MP[0]))
        u_a (.clk(clk), .rst_n(rst_n), .avs(if_a), .err_sticky(err_a), .reads_served(srv_a));
    avmm_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(P_W[1]), .READ_LATENCY(P_RL[1]), .MAX_PENDING(P_MP[1]))
        u_b (.clk(clk), .rst_n(rst_n), .avs(if_b), .err_sticky(err_b), .reads_served(srv_b));
    avmm_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(P_W[2]), .READ_LATENCY(P_RL[2]), .MAX_PENDING(P_MP[2]))
        u_c (.clk(clk), .rst_n(rst_n), .avs(if_c), .err_sticky(err_c), .reads_served(srv_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic out_t get_out(input int d);
        out_t o;
        case (d)
            0: begin
                o.wr = if_a.slave_waitrequest; o.v = if_a.slave_readdatavalid;
                o.rd = if_a.slave_readdata; o.err = err_a; o.srv = srv_a;
            end
            1: begin
                o.wr = if_b.slave_waitrequest; o.v = if_b.slave_readdatavalid;
                o.rd = if_b.slave_readdata; o.err = err_b; o.srv = srv_b;
            end
            default: begin
                o.wr = if_c.slave_waitrequest; o.v = if_c.slave_readdatavalid;
                o.rd = if_c.slave_readdata; o.err = err_c; o.srv = srv_c;
            end
        endcase
        return o;
    endfunction

    task automatic set_in(input int d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        case (d)
            0: begin
                if_a.slave_read = rd; if_a.slave_write = wr;
                if_a.slave_address = addr; if_a.slave_writedata = wd;
            end
            1: begin
                if_b.slave_read = rd; if_b.slave_write = wr;
                if_b.slave_address = addr; if_b.slave_writedata = wd;
            end
            default: begin
                if_c.slave_read = rd; if_c.slave_write = wr;
                if_c.slave_address = addr; if_c.slave_writedata = wd;
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Holds a command until accepted; reports how many waitrequest-high cycles it saw.
    task automatic bus_cmd(input int d, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd, output int nwait);
        out_t o;
        bit   ok;
        nwait = 0;
        ok    = 1'b0;
        set_in(d, rd, wr, addr, wd);
        for (int i = 0; i < 40 && !ok; i++) begin
            o = get_out(d);
            @(posedge clk);
            #1;
            if (!o.wr) ok = 1'b1;
            else nwait++;
        end
        set_in(d, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("accept_in_bound", ok, 1'b1);
    endtask

    // Called just after the accept edge; edges = further edges until valid shows.
    task automatic wait_valid(input int d, input int max, output bit got,
                              output int edges, output logic [31:0] data);
        out_t o;
        got = 1'b0;
        edges = 0;
        data = 32'h0;
        for (int e = 0; e <= max && !got; e++) begin
            o = get_out(d);
            if (o.v) begin
                got = 1'b1;
                edges = e;
                data = o.rd;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic count_v(input int d, input int n, output int c);
        out_t o;
        c = 0;
        for (int i = 0; i < n; i++) begin
            o = get_out(d);
            if (o.v) c++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_check(input int d, input string name, input logic [31:0] addr,
                              input logic [31:0] exp);
        int          nw, edges;
        bit          got;
        logic [31:0] data;
        bus_cmd(d, 1'b1, 1'b0, addr, 32'h0, nw);
        wait_valid(d, 12, got, edges, data);
        chk1({name, "_valid"}, got, 1'b1);
        chk32({name, "_latency"}, edges, P_RL[d] - 1);
        chk32({name, "_data"}, data, exp);
    endtask

    // Randomized traffic checked against a queue model of in-flight reads.
    task automatic run_random(input int d, input int ncyc);
        int          w, rl, mp, stall, edge_n, served_m, idx, k;
        resp_t       q[$];
        logic [31:0] mm [16];
        bit          kn [16];
        bit          err_m, exp_v, exp_kn, active, cur_rd, cur_wr, acc, oor, exp_wait;
        logic [31:0] exp_d, cur_addr, cur_wd;
        out_t        o;
        w = P_W[d]; rl = P_RL[d]; mp = P_MP[d];
        stall = 0; edge_n = 0; served_m = 0; idx = 0;
        err_m = 0; exp_v = 0; exp_kn = 0; active = 0; cur_rd = 0; cur_wr = 0;
        exp_d = 32'h0; cur_addr = 32'h0; cur_wd = 32'h0;
        for (int i = 0; i < 16; i++) kn[i] = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            o = get_out(d);
            exp_wait = !(stall == w && q.size() < mp);
            chk1("rnd_waitrequest", o.wr, exp_wait);
            chk1("rnd_readdatavalid", o.v, exp_v);
            if (exp_v && exp_kn) chk32("rnd_readdata", o.rd, exp_d);
            chk32("rnd_reads_served", {16'h0, o.srv}, served_m % 65536);
            chk1("rnd_err_sticky", o.err, err_m);
            if (!active) begin
                if (c < ncyc - 16 && $urandom_range(2, 0) != 0) begin
                    k = $urandom_range(19, 0);
                    cur_wr = (k < 8) || (k == 19);
                    cur_rd = (k >= 8);
                    cur_addr = {26'h0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
                    if ($urandom_range(15, 0) == 0)
                        cur_addr = cur_addr | (32'h1 << $urandom_range(31, 12));
                    cur_wd = $urandom;
                    active = 1'b1;
                end
            end else if ($urandom_range(15, 0) == 0) begin
                active = 1'b0;
            end
            set_in(d, active & cur_rd, active & cur_wr, cur_addr, cur_wd);
            acc = active && !exp_wait;
            oor = (cur_addr >> 2) >= 32'd1024;
            idx = int'(cur_addr[5:2]);
            edge_n++;
            if (!active || acc) stall = 0;
            else if (stall < w) stall++;
            if (acc) begin
                if ((cur_rd && cur_wr) || oor) err_m = 1'b1;
                if (cur_wr && !oor) begin
                    mm[idx] = cur_wd;
                    kn[idx] = 1'b1;
                end
                if (cur_rd && !cur_wr)
                    q.push_back('{edge_n + rl - 1, oor ? 32'hDEAD_BEEF : mm[idx], oor || kn[idx]});
                active = 1'b0;
            end
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].rise == edge_n) begin
                exp_v = 1'b1;
                exp_d = q[0].data;
                exp_kn = q[0].known;
                void'(q.pop_front());
                served_m++;
            end
            @(posedge clk);
            #1;
        end
        set_in(d, 1'b0, 1'b0, 32'h0, 32'h0);
        chk32("rnd_drained", q.size(), 0);
    endtask

    initial begin
        vec_t        tbl [9];
        out_t        o;
        int          nw, edges, cnt, reads_done, acc_n, got_n, inflight, peak, full_open, full_seen;
        bit          got;
        logic [31:0] data;
        logic [31:0] rx[$];

        tbl[0] = '{1'b1, 32'h0000_0040, 32'h0001_0000};
        tbl[1] = '{1'b0, 32'h0000_0040, 32'h0001_0000};
        tbl[2] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 32'h0000_0047, 32'hCAFE_F00D};
        tbl[4] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678};
        tbl[5] = '{1'b0, 32'h0000_0FFC, 32'h1234_5678};
        tbl[6] = '{1'b1, 32'h0000_0045, 32'h0BAD_F00D};
        tbl[7] = '{1'b0, 32'h0000_0044, 32'h0BAD_F00D};
        tbl[8] = '{1'b0, 32'h0000_0040, 32'h0001_0000};

        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();

        // Reset / idle state
        o = get_out(0);
        chk1("rst_a_waitrequest", o.wr, 1'b0);
        chk1("rst_a_readdatavalid", o.v, 1'b0);
        chk32("rst_a_readdata", o.rd, 32'h0);
        chk1("rst_a_err", o.err, 1'b0);
        chk32("rst_a_served", {16'h0, o.srv}, 32'h0);
        o = get_out(1);
        chk1("rst_b_waitrequest", o.wr, 1'b1);
        o = get_out(2);
        chk1("rst_c_waitrequest", o.wr, 1'b0);

        // Table-driven write/read vectors on the zero-wait instance
        reads_done = 0;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_wr) begin
                bus_cmd(0, 1'b0, 1'b1, tbl[i].addr, tbl[i].data, nw);
                chk32("tbl_wr_nowait", nw, 0);
            end else begin
                bus_cmd(0, 1'b1, 1'b0, tbl[i].addr, 32'h0, nw);
                chk32("tbl_rd_nowait", nw, 0);
                wait_valid(0, 12, got, edges, data);
                reads_done++;
                chk1("tbl_rd_valid", got, 1'b1);
                chk32("tbl_rd_latency", edges, P_RL[0] - 1);
                chk32("tbl_rd_data", data, tbl[i].data);
                chk32("tbl_served", {16'h0, srv_a}, reads_done);
                @(posedge clk);
                #1;
                o = get_out(0);
                chk1("tbl_valid_pulse", o.v, 1'b0);
                chk32("tbl_data_hold", o.rd, tbl[i].data);
            end
        end
        chk1("tbl_no_err", err_a, 1'b0);

        // Read+write together: write wins, no response, sticky error
        bus_cmd(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0005, nw);
        count_v(0, 6, cnt);
        chk32("rw_no_valid", cnt, 0);
        chk1("rw_err", err_a, 1'b1);
        read_check(0, "rw_mem", 32'h0000_0010, 32'h0000_0005);
        // Out-of-range write is dropped, out-of-range read returns the marker
        bus_cmd(0, 1'b0, 1'b1, 32'h8000_0040, 32'h0000_0099, nw);
        read_check(0, "oor_wr_dropped", 32'h0000_0040, 32'h0001_0000);
        read_check(0, "oor_rd", 32'h8000_0000, 32'hDEAD_BEEF);

        // Reset one cycle after a read accept: response flushed, memory kept
        bus_cmd(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, nw);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_v(0, 8, cnt);
        chk32("midrst_no_valid", cnt, 0);
        chk32("midrst_served", {16'h0, srv_a}, 32'h0);
        chk1("midrst_err", err_a, 1'b0);
        read_check(0, "midrst_mem_kept", 32'h0000_0040, 32'h0001_0000);
        chk1("oor_fresh_err_clear", err_a, 1'b0);
        read_check(0, "oor_fresh", 32'h8000_0004, 32'hDEAD_BEEF);
        chk1("oor_fresh_err", err_a, 1'b1);

        // Stall behaviour with three wait cycles
        bus_cmd(1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_BEEF, nw);
        chk32("stall_wr_cycles", nw, 3);
        bus_cmd(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, nw);
        chk32("stall_rd_cycles", nw, 3);
        wait_valid(1, 12, got, edges, data);
        chk1("stall_rd_valid", got, 1'b1);
        chk32("stall_rd_data", data, 32'h0000_BEEF);
        @(posedge clk);
        #1;
        set_in(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
        o = get_out(1);
        chk1("drop_first_wait", o.wr, 1'b1);
        @(posedge clk);
        #1;
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
        o = get_out(1);
        chk1("drop_idle_wait", o.wr, 1'b1);
        @(posedge clk);
        #1;
        bus_cmd(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, nw);
        chk32("drop_reissue_cycles", nw, 3);
        wait_valid(1, 12, got, edges, data);
        chk32("drop_reissue_data", data, 32'h0000_BEEF);

        // Back-pressure: four continuous reads, at most two in flight
        for (int i = 0; i < 4; i++) begin
            bus_cmd(2, 1'b0, 1'b1, 32'(i * 4), 32'h100 + 32'(i), nw);
        end
        acc_n = 0; got_n = 0; peak = 0; full_open = 0; full_seen = 0;
        for (int c = 0; c < 40 && got_n < 4; c++) begin
            o = get_out(2);
            if (o.v) begin
                rx.push_back(o.rd);
                got_n++;
            end
            inflight = acc_n - got_n;
            if (inflight > peak) peak = inflight;
            if (inflight == 2 && !o.wr) full_open++;
            if (inflight == 2 && o.wr) full_seen++;
            if (acc_n < 4) set_in(2, 1'b1, 1'b0, 32'(acc_n * 4), 32'h0);
            else set_in(2, 1'b0, 1'b0, 32'h0, 32'h0);
            @(posedge clk);
            #1;
            if (acc_n < 4 && !o.wr) acc_n++;
        end
        set_in(2, 1'b0, 1'b0, 32'h0, 32'h0);
        chk32("bp_pulses", got_n, 4);
        chk32("bp_peak_inflight", peak, 2);
        chk32("bp_wait_low_when_full", full_open, 0);
        chk1("bp_full_seen", full_seen > 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < rx.size()) chk32("bp_order_data", rx[i], 32'h100 + 32'(i));
        end

        // Randomized traffic on each configuration
        do_reset();
        run_random(0, 700);
        run_random(1, 700);
        run_random(2, 700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
